// File: rtl/fifo_lvl.sv
// Synchronous show-ahead FIFO with fill level, programmable almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and synchronous flush.
module fifo_lvl #(
    parameter int B     = 8,
    parameter int W     = 4,
    parameter int AF_TH = (1 << W) - 1,
    parameter int AE_TH = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr,
    input  logic         rd,
    input  logic         flush,
    input  logic         clr_err,
    input  logic [B-1:0] w_data,
    output logic [B-1:0] r_data,
    output logic         full,
    output logic         empty,
    output logic         almost_full,
    output logic         almost_empty,
    output logic [W:0]   count,
    output logic         overflow,
    output logic         underflow
);

    localparam logic [W:0] DEPTH_L = {1'b1, {W{1'b0}}};
    localparam logic [W:0] AF_L    = AF_TH[W:0];
    localparam logic [W:0] AE_L    = AE_TH[W:0];

    logic [B-1:0] mem_q [(1<<W)];
    logic [W-1:0] wr_ptr_q, wr_ptr_d;
    logic [W-1:0] rd_ptr_q, rd_ptr_d;
    logic [W:0]   count_q, count_d;
    logic         ovf_q, ovf_d;
    logic         udf_q, udf_d;
    logic         full_s, empty_s;
    logic         do_wr_s, do_rd_s;
    logic         ovf_ev_s, udf_ev_s;

    assign full_s  = (count_q == DEPTH_L);
    assign empty_s = (count_q == {(W+1){1'b0}});

    // Next-state decode: flush overrides strobes; a pop frees the slot a full write needs.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_wr_s  = 1'b0;
        do_rd_s  = 1'b0;
        ovf_ev_s = 1'b0;
        udf_ev_s = 1'b0;
        if (flush) begin
            wr_ptr_d = {W{1'b0}};
            rd_ptr_d = {W{1'b0}};
            count_d  = {(W+1){1'b0}};
        end else begin
            do_rd_s  = rd && !empty_s;
            do_wr_s  = wr && (!full_s || do_rd_s);
            ovf_ev_s = wr && full_s && !rd;
            udf_ev_s = rd && empty_s;
            if (do_wr_s) begin
                wr_ptr_d = wr_ptr_q + W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_rd_s) begin
                rd_ptr_d = rd_ptr_q + W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_wr_s, do_rd_s})
                2'b10:   count_d = count_q + (W+1)'(1);
                2'b01:   count_d = count_q - (W+1)'(1);
                default: count_d = count_q;
            endcase
        end
        ovf_d = ovf_ev_s || (ovf_q && !clr_err);
        udf_d = udf_ev_s || (udf_q && !clr_err);
    end

    // Pointer, level and sticky error registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= {W{1'b0}};
            rd_ptr_q <= {W{1'b0}};
            count_q  <= {(W+1){1'b0}};
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage array, deliberately not reset.
    always_ff @(posedge clk) begin
        if (do_wr_s) begin
            mem_q[wr_ptr_q] <= w_data;
        end
    end

    assign r_data       = empty_s ? {B{1'b0}} : mem_q[rd_ptr_q];
    assign full         = full_s;
    assign empty        = empty_s;
    assign almost_full  = (count_q >= AF_L);
    assign almost_empty = (count_q <= AE_L);
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_fifo_lvl.sv
// Self-checking bench for fifo_lvl: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_fifo_lvl;
    localparam int B = 3, W = 2, AF_TH = 3, AE_TH = 1, D = 4;

    logic         clk = 1'b0, reset = 1'b0;
    logic         wr = 1'b0, rd = 1'b0, flush = 1'b0, clr_err = 1'b0;
    logic [B-1:0] w_data = '0;
    logic [B-1:0] r_data;
    logic         full, empty, almost_full, almost_empty, overflow, underflow;
    logic [W:0]   count;

    int errors = 0, checks = 0;
    int mq[$];
    bit m_ovf = 1'b0, m_udf = 1'b0;

    fifo_lvl #(.B(B), .W(W), .AF_TH(AF_TH), .AE_TH(AE_TH)) dut (
        .clk(clk), .reset(reset), .wr(wr), .rd(rd), .flush(flush), .clr_err(clr_err),
        .w_data(w_data), .r_data(r_data), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // One clock with the given strobes; the model advances by the FIFO's queue rules.
    task automatic cycle(input bit w, input bit r, input bit f, input bit c, input logic [B-1:0] d);
        int  sz;
        bit  pop, push;
        wr = w; rd = r; flush = f; clr_err = c; w_data = d;
        @(posedge clk);
        sz = mq.size();
        if (f) begin
            mq.delete();
            m_ovf = m_ovf && !c;
            m_udf = m_udf && !c;
        end else begin
            pop  = r && (sz > 0);
            push = w && ((sz < D) || pop);
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(int'(d));
            m_ovf = (w && (sz == D) && !r) || (m_ovf && !c);
            m_udf = (r && (sz == 0)) || (m_udf && !c);
        end
        #1;
        wr = 1'b0; rd = 1'b0; flush = 1'b0; clr_err = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", count); end
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL rst_empty_full: got %b%b expected 10", empty, full); end
        checks++; if (almost_empty !== 1'b1 || almost_full !== 1'b0) begin errors++; $display("FAIL rst_almost: got ae=%b af=%b expected ae=1 af=0", almost_empty, almost_full); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0 || r_data !== 3'd0) begin errors++; $display("FAIL rst_flags: got ovf=%b udf=%b rd=%0d expected 0 0 0", overflow, underflow, r_data); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fill_overflow();
        logic [B-1:0] exp_seq [4] = '{3'd5, 3'd6, 3'd7, 3'd1};
        cycle(1, 0, 0, 0, 3'd5); cycle(1, 0, 0, 0, 3'd6); cycle(1, 0, 0, 0, 3'd7);
        checks++; if (count !== 3'd3 || almost_full !== 1'b1 || almost_empty !== 1'b0) begin errors++; $display("FAIL fill3: got cnt=%0d af=%b ae=%b expected 3 1 0", count, almost_full, almost_empty); end
        checks++; if (r_data !== 3'd5 || empty !== 1'b0) begin errors++; $display("FAIL fill3_head: got %0d empty=%b expected 5 0", r_data, empty); end
        cycle(1, 0, 0, 0, 3'd1); cycle(1, 0, 0, 0, 3'd2);
        checks++; if (count !== 3'd4 || full !== 1'b1 || overflow !== 1'b1) begin errors++; $display("FAIL ovf: got cnt=%0d full=%b ovf=%b expected 4 1 1", count, full, overflow); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (r_data !== exp_seq[i]) begin errors++; $display("FAIL pop_seq[%0d]: got %0d expected %0d", i, r_data, exp_seq[i]); end
            cycle(0, 1, 0, 0, 3'd0);
        end
        checks++; if (count !== 3'd0 || empty !== 1'b1 || r_data !== 3'd0) begin errors++; $display("FAIL drained: got cnt=%0d empty=%b rd=%0d expected 0 1 0", count, empty, r_data); end
        cycle(0, 0, 0, 1, 3'd0);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b expected 0", overflow); end
    endtask

    task automatic test_underflow();
        cycle(0, 1, 0, 0, 3'd0);
        checks++; if (underflow !== 1'b1 || count !== 3'd0) begin errors++; $display("FAIL udf_set: got udf=%b cnt=%0d expected 1 0", underflow, count); end
        cycle(0, 1, 0, 1, 3'd0);
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL udf_set_wins: got %b expected 1", underflow); end
        cycle(0, 0, 0, 1, 3'd0);
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL udf_clr: got %b expected 0", underflow); end
    endtask

    task automatic test_full_rw();
        logic [B-1:0] exp_seq [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd7, 3'd7, 3'd7, 3'd7};
        for (int i = 1; i <= 4; i++) cycle(1, 0, 0, 0, 3'(i));
        for (int i = 0; i < 8; i++) begin
            checks++; if (r_data !== exp_seq[i]) begin errors++; $display("FAIL rw_pop[%0d]: got %0d expected %0d", i, r_data, exp_seq[i]); end
            cycle(1, 1, 0, 0, 3'd7);
            checks++; if (count !== 3'd4 || full !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL rw_level[%0d]: got cnt=%0d full=%b ovf=%b expected 4 1 0", i, count, full, overflow); end
        end
        cycle(0, 0, 1, 0, 3'd0);
    endtask

    task automatic test_flush();
        cycle(0, 1, 0, 0, 3'd0);
        cycle(1, 0, 0, 0, 3'd6); cycle(1, 0, 0, 0, 3'd5);
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL pre_flush: got %0d expected 2", count); end
        cycle(1, 0, 1, 0, 3'd4);
        checks++; if (count !== 3'd0 || empty !== 1'b1) begin errors++; $display("FAIL flush: got cnt=%0d empty=%b expected 0 1", count, empty); end
        checks++; if (underflow !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL flush_flags: got udf=%b ovf=%b expected 1 0", underflow, overflow); end
        cycle(1, 0, 0, 0, 3'd3);
        checks++; if (r_data !== 3'd3 || count !== 3'd1) begin errors++; $display("FAIL post_flush: got rd=%0d cnt=%0d expected 3 1", r_data, count); end
        cycle(0, 1, 0, 1, 3'd0);
    endtask

    task automatic test_async_reset();
        cycle(0, 1, 0, 0, 3'd0);
        cycle(1, 0, 0, 0, 3'd1); cycle(1, 0, 0, 0, 3'd2); cycle(1, 0, 0, 0, 3'd3);
        checks++; if (count !== 3'd3 || underflow !== 1'b1) begin errors++; $display("FAIL pre_arst: got cnt=%0d udf=%b expected 3 1", count, underflow); end
        #2 reset = 1'b0;
        #1;
        mq.delete(); m_ovf = 1'b0; m_udf = 1'b0;
        checks++; if (count !== 3'd0 || empty !== 1'b1 || almost_empty !== 1'b1 || r_data !== 3'd0 || underflow !== 1'b0) begin
            errors++; $display("FAIL arst: got cnt=%0d empty=%b ae=%b rd=%0d udf=%b expected 0 1 1 0 0", count, empty, almost_empty, r_data, underflow);
        end
        @(posedge clk); #2 reset = 1'b1;
        @(posedge clk); #1;
        cycle(1, 0, 0, 0, 3'd4);
        checks++; if (r_data !== 3'd4) begin errors++; $display("FAIL arst_resume: got %0d expected 4", r_data); end
        cycle(0, 1, 0, 0, 3'd0);
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL arst_pop: got %0d expected 0", count); end
    endtask

    task automatic test_random();
        logic [B-1:0] exp_rd;
        int n;
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 7) == 0), 3'($urandom));
            n = mq.size();
            exp_rd = (n > 0) ? 3'(mq[0]) : 3'd0;
            checks++; if (count !== 3'(n)) begin errors++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", i, count, n); end
            checks++; if (r_data !== exp_rd) begin errors++; $display("FAIL rnd_rdata[%0d]: got %0d expected %0d", i, r_data, exp_rd); end
            checks++; if (full !== (n == D) || empty !== (n == 0)) begin errors++; $display("FAIL rnd_fe[%0d]: got full=%b empty=%b level=%0d", i, full, empty, n); end
            checks++; if (almost_full !== (n >= AF_TH) || almost_empty !== (n <= AE_TH)) begin errors++; $display("FAIL rnd_almost[%0d]: got af=%b ae=%b level=%0d", i, almost_full, almost_empty, n); end
            checks++; if (overflow !== m_ovf || underflow !== m_udf) begin errors++; $display("FAIL rnd_err[%0d]: got ovf=%b udf=%b expected %b %b", i, overflow, underflow, m_ovf, m_udf); end
        end
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_underflow();
        test_full_rw();
        test_flush();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
